// File: rtl/core_report_fifo.sv
// Buffers the core's non-stallable register reports and drains them over valid/ready.
// Drops on overflow are counted and flagged; occupancy high-water mark is kept for debug.
module core_report_fifo #(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_BITS = 3,
    parameter int DROP_BITS  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            to_peripheral,
    input  logic [DATA_WIDTH-1:0] to_peripheral_data,
    input  logic                  to_peripheral_valid,
    output logic [1:0]            out_tag,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    input  logic                  clear_stats,
    output logic [DEPTH_BITS:0]   count,
    output logic [DEPTH_BITS:0]   max_count,
    output logic                  overflow,
    output logic [DROP_BITS-1:0]  drop_count
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int EW    = DATA_WIDTH + 2;
    localparam logic [DEPTH_BITS:0]  PTR_ONE  = {{DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [DROP_BITS-1:0] DROP_ONE = {{(DROP_BITS-1){1'b0}}, 1'b1};
    localparam logic [DROP_BITS-1:0] DROP_MAX = {DROP_BITS{1'b1}};

    // CORE is a tag only; a negative index is meaningless but harmless.
    if (CORE < 0) begin : g_core_tag_negative
    end

    logic [EW-1:0]          mem_q [DEPTH];
    logic [DEPTH_BITS:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS:0]    count_q, count_d, max_count_q, max_count_d;
    logic                   overflow_q, overflow_d, out_valid_q, out_valid_d;
    logic [DROP_BITS-1:0]   drop_count_q, drop_count_d;
    logic [EW-1:0]          head_q, head_d, wr_entry_s;
    logic                   full_s, pop_s, push_s, drop_s, wr_en_s;

    assign wr_entry_s = {to_peripheral, to_peripheral_data};
    assign full_s     = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                        (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
    assign pop_s      = out_valid_q & out_ready;
    assign push_s     = to_peripheral_valid & (~full_s | pop_s);
    assign drop_s     = to_peripheral_valid & full_s & ~pop_s & ~flush;
    assign wr_en_s    = push_s & ~flush & ~reset;

    // Next-state for pointers, occupancy, registered head and statistics.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        head_d       = head_q;
        max_count_d  = max_count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + PTR_ONE;
            end else if (pop_s && !push_s) begin
                count_d = count_q - PTR_ONE;
            end else begin
                count_d = count_q;
            end
            // The head register mirrors the slot at the next read pointer,
            // which may be the slot being written this very cycle.
            if (push_s && (wr_ptr_q == rd_ptr_d)) begin
                head_d = wr_entry_s;
            end else begin
                head_d = mem_q[rd_ptr_d[DEPTH_BITS-1:0]];
            end
        end

        out_valid_d = (count_d != '0);

        if (clear_stats) begin
            max_count_d = count_d;
        end else if (count_d > max_count_q) begin
            max_count_d = count_d;
        end else begin
            max_count_d = max_count_q;
        end

        if (drop_s) begin
            overflow_d = 1'b1;
            if (clear_stats) begin
                drop_count_d = DROP_ONE;
            end else if (drop_count_q != DROP_MAX) begin
                drop_count_d = drop_count_q + DROP_ONE;
            end else begin
                drop_count_d = drop_count_q;
            end
        end else if (clear_stats) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else begin
            overflow_d   = overflow_q;
            drop_count_d = drop_count_q;
        end
    end

    // Control and statistics registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            max_count_q  <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            out_valid_q  <= 1'b0;
            head_q       <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            max_count_q  <= max_count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            out_valid_q  <= out_valid_d;
            head_q       <= head_d;
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= wr_entry_s;
        end
    end

    assign out_tag    = head_q[EW-1 -: 2];
    assign out_data   = head_q[DATA_WIDTH-1:0];
    assign out_valid  = out_valid_q;
    assign count      = count_q;
    assign max_count  = max_count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_core_report_fifo.sv
// Scoreboard bench for core_report_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_core_report_fifo;

    localparam int DW       = 32;
    localparam int DB       = 3;
    localparam int XB       = 4;
    localparam int DEPTH    = 8;
    localparam int DROP_SAT = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    tag_in = 2'd0;
    logic [DW-1:0] data_in = '0;
    logic          tpv = 1'b0;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic          clear_stats = 1'b0;
    logic [1:0]    out_tag;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [DB:0]   count, max_count;
    logic          overflow;
    logic [XB-1:0] drop_count;

    always #5 clock = ~clock;

    core_report_fifo #(.CORE(0), .DATA_WIDTH(DW), .DEPTH_BITS(DB), .DROP_BITS(XB)) dut (
        .clock(clock), .reset(reset),
        .to_peripheral(tag_in), .to_peripheral_data(data_in), .to_peripheral_valid(tpv),
        .out_tag(out_tag), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .clear_stats(clear_stats),
        .count(count), .max_count(max_count), .overflow(overflow), .drop_count(drop_count)
    );

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] mq[$];
    int m_max = 0, m_ov = 0, m_dc = 0;
    logic [DW+1:0] mon_e;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check post-edge state against the model, then drive and predict.
    task automatic step(input bit v, input logic [1:0] t, input logic [DW-1:0] d,
                        input bit rdy, input bit fl = 1'b0, input bit cl = 1'b0, input bit rs = 1'b0);
        bit full, pop, accept, dropped;
        @(posedge clock);
        #1;
        if (checking) begin
            chk("count", count, mq.size());
            chk("out_valid", out_valid, (mq.size() != 0) ? 1 : 0);
            chk("max_count", max_count, m_max);
            chk("overflow", overflow, m_ov);
            chk("drop_count", drop_count, m_dc);
        end
        reset       = rs;
        tpv         = v;
        tag_in      = t;
        data_in     = d;
        out_ready   = (rs || fl) ? 1'b0 : rdy;
        flush       = fl;
        clear_stats = cl;
        if (rs) begin
            mq.delete();
            exp_q.delete();
            m_max = 0; m_ov = 0; m_dc = 0;
        end else begin
            full    = (mq.size() == DEPTH);
            pop     = (mq.size() > 0) && out_ready;
            accept  = v && (!full || pop);
            dropped = v && full && !pop && !fl;
            if (fl) begin
                mq.delete();
                exp_q.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (accept) begin
                    mq.push_back({t, d});
                    exp_q.push_back({t, d});
                end
            end
            if (dropped) begin
                m_ov = 1;
                m_dc = cl ? 1 : ((m_dc < DROP_SAT) ? m_dc + 1 : DROP_SAT);
            end else if (cl) begin
                m_ov = 0;
                m_dc = 0;
            end
            if (cl) m_max = mq.size();
            else if (mq.size() > m_max) m_max = mq.size();
        end
    endtask

    // Monitor: every accepted head must match the oldest expected report.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head_unexpected: got data %0d expected no entry", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("head", {out_tag, out_data}, mon_e);
            end
        end
    end

    initial begin
        step(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        checking = 1'b1;
        step(1'b0, 2'd0, '0, 1'b0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);

        // Three reports held, then drained in order.
        step(1'b1, 2'd0, 32'd10, 1'b0);
        step(1'b1, 2'd0, 32'd20, 1'b0);
        step(1'b1, 2'd0, 32'd30, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0);
        chk("hold_count", count, 3);
        chk("hold_data0", out_data, 10);
        step(1'b0, 2'd0, '0, 1'b0);
        chk("hold_data1", out_data, 10);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, '0, 1'b1);
        step(1'b0, 2'd0, '0, 1'b0);
        chk("drain_count", count, 0);
        chk("drain_max", max_count, 3);

        // Ten back-to-back reports into eight slots.
        for (int i = 1; i <= 10; i++) step(1'b1, 2'd1, 32'(i), 1'b0);
        step(1'b0, 2'd0, '0, 1'b0);
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drop_count, 2);
        for (int i = 0; i < 9; i++) step(1'b0, 2'd0, '0, 1'b1);

        // Full with simultaneous pop accepts the new report.
        for (int i = 0; i < 8; i++) step(1'b1, 2'd2, 32'(100 + i), 1'b0);
        step(1'b1, 2'd2, 32'd99, 1'b1);
        step(1'b0, 2'd0, '0, 1'b0);
        chk("fullpop_count", count, 8);
        chk("fullpop_drops", drop_count, 2);
        for (int i = 0; i < 9; i++) step(1'b0, 2'd0, '0, 1'b1);

        // Reset mid-stream.
        for (int i = 0; i < 9; i++) step(1'b1, 2'd3, 32'(200 + i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, '0, 1'b1);
        step(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'd0, '0, 1'b0);
        chk("mrst_count", count, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_drops", drop_count, 0);
        chk("mrst_max", max_count, 0);

        // Flush with a concurrent report.
        for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 32'(300 + i), 1'b0);
        step(1'b1, 2'd1, 32'd55, 1'b0, 1'b1);
        step(1'b0, 2'd0, '0, 1'b0);
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_drops", drop_count, 0);

        // clear_stats against a concurrent drop, then saturation.
        for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 32'(400 + i), 1'b0);
        step(1'b1, 2'd0, 32'd65, 1'b0);
        step(1'b1, 2'd0, 32'd66, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'd0, '0, 1'b0);
        chk("clrdrop_ovf", overflow, 1);
        chk("clrdrop_drops", drop_count, 1);
        for (int i = 0; i < 20; i++) step(1'b1, 2'd3, 32'(500 + i), 1'b0);
        step(1'b0, 2'd0, '0, 1'b0);
        chk("sat_drops", drop_count, 15);
        step(1'b1, 2'd3, 32'd777, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'd0, '0, 1'b0);
        chk("satclr_drops", drop_count, 0);
        chk("satclr_ovf", overflow, 0);
        chk("satclr_max", max_count, 8);
        for (int i = 0; i < 9; i++) step(1'b0, 2'd0, '0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 55, 2'($urandom_range(0, 3)), DW'($urandom),
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 199) < 1);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 2'd0, '0, 1'b1);
        step(1'b0, 2'd0, '0, 1'b0);
        chk("end_scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_report_fifo.md
Name: core_report_fifo

Overview:
- Downstream consumer of the core's register-report outputs (to_peripheral, to_peripheral_data, to_peripheral_valid).
- The core emits one report per qualifying writeback (s1, s2–s9) and cannot be back-pressured. This block buffers those reports in a FIFO and drains them to the host/peripheral side over a valid/ready handshake.
- Drops are detected, counted and flagged; occupancy statistics are exposed for debug.

Parameters:
CORE, 0, core index tag, informational; drives no logic.
DATA_WIDTH, 32, width of report data.
DEPTH_BITS, 3, log2 of FIFO depth (default 8 entries).
DROP_BITS, 16, width of the saturating drop counter.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
to_peripheral  input  2  report tag from core.
to_peripheral_data  input  DATA_WIDTH  report value from core.
to_peripheral_valid  input  1  one-cycle strobe: report present this cycle.
out_tag  output  2  head entry tag.
out_data  output  DATA_WIDTH  head entry data.
out_valid  output  1  head entry valid (FIFO non-empty).
out_ready  input  1  consumer accepts head this cycle.
flush  input  1  discard all buffered entries.
clear_stats  input  1  clear overflow, drop_count and max_count.
count  output  DEPTH_BITS+1  current occupancy.
max_count  output  DEPTH_BITS+1  high-water occupancy since last clear.
overflow  output  1  sticky: at least one report dropped.
drop_count  output  DROP_BITS  saturating number of dropped reports.

Behaviour:
- Reset (sync, active-high):
  - Read/write pointers, count, max_count, overflow and drop_count go to 0.
  - out_valid is 0. out_tag and out_data are don't-care while out_valid is 0 and read as 0 after reset.
  - Storage contents are not reset.
  - Reset dominates flush, clear_stats and all traffic in the same cycle.
- Storage:
  - 2^DEPTH_BITS entries of {tag, data}.
  - Pointers are DEPTH_BITS+1 bits and wrap naturally. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- Output (show-ahead):
  - out_valid = !empty.
  - out_tag and out_data present the entry at the read pointer in the same cycle out_valid is high.
  - pop = out_valid & out_ready. On pop, the read pointer advances at the next edge.
  - out_valid, out_tag and out_data are held stable while out_valid=1 and out_ready=0.
- Push:
  - push = to_peripheral_valid & (!full | pop). An entry is written at the write pointer and the pointer advances.
  - Full with a simultaneous pop: push is accepted and count stays unchanged.
- Write-to-read latency: a report accepted at edge N appears on out_* (out_valid=1) after edge N when the FIFO was empty. There is no bypass of the storage.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- max_count: updated each cycle to max(max_count, next count).
- Drop:
  - A drop occurs when to_peripheral_valid=1, full=1 and pop=0. The entry is discarded.
  - On a drop, overflow is set to 1 and drop_count increments, saturating at all-ones (no wrap).
- clear_stats:
  - Sets overflow=0, drop_count=0 and max_count=next count.
  - A drop in the same cycle wins: overflow=1, drop_count=1.
- flush:
  - Next state is empty: both pointers to 0 and count=0. Any push or pop in the same cycle is discarded.
  - The incoming report is not counted as a drop.
  - overflow, drop_count and max_count are unaffected.
- Flow: no combinational path from out_ready to any input-side decision other than the full-with-pop acceptance described above.

Test Plan:
- Reset, then 3 reports (tags 0, data 10/20/30) with out_ready=0 -> count=3, out_valid=1, out_data=10 held. Then out_ready=1 for 3 cycles -> out_data 10, 20, 30 in order, then out_valid=0, count=0, max_count=3.
- 10 back-to-back reports (data 1..10), out_ready=0, DEPTH_BITS=3 -> count=8, overflow=1, drop_count=2. Draining yields 1..8 only.
- FIFO full (8 entries) with out_ready=1 and to_peripheral_valid=1 (data 99) in the same cycle -> no drop, count stays 8, 99 is the last entry drained.
- Reset mid-stream with count=5, overflow=1 -> next cycle count=0, out_valid=0, overflow=0, drop_count=0, max_count=0.
- flush asserted while count=4 and a report arrives in the same cycle -> count=0, out_valid=0, drop_count unchanged. clear_stats with a concurrent drop -> overflow=1, drop_count=1.
- DROP_BITS=4: force 20 drops -> drop_count saturates at 15 and stays there until clear_stats.
